inst_prefetch: RTL and testbench

Instruction byte prefetch unit for the 6502 core. It acts as bus master on the instruction-memory port and fetches sequential bytes starting at the current fetch PC. It writes them into a 16-entry circular byte queue and presents the oldest three bytes to the decoder. The decoder consumes 1–3 bytes per instruction; a branch or jump flushes the queue and restarts fetch at a new PC.

---
 rtl/inst_prefetch.sv | 152 +++++++++++++++
 tb/tb_inst_prefetch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch.sv
// ---------------------------------------------------------------------------
// inst_prefetch
//   Instruction byte prefetch unit for the 6502 core. Acts as bus master on
//   the instruction-memory port, fetching sequential bytes from the fetch PC
//   into a circular byte queue, and presents the oldest three bytes to the
//   decoder. The decoder consumes 1..3 bytes per cycle; a flush discards the
//   queue and restarts fetching at a new PC.
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   o_mem_req         registered fetch request
//   o_mem_addr        registered request address (== fetch PC)
//   i_mem_ack         transfer completes in a cycle with req & ack
//   i_mem_rdata       byte of the completing transfer
//   i_flush           discard queue, restart fetch at i_flush_pc
//   i_flush_pc        new fetch PC
//   i_pop_len         bytes consumed this cycle (0..3)
//   o_q_byte0..2      bytes at read pointer +0/+1/+2
//   o_q_count         number of valid bytes (0..DEPTH)
//   o_q_pc            address of o_q_byte0
//   o_pop_err         one-cycle pulse after a pop larger than the queue
// ---------------------------------------------------------------------------
module inst_prefetch #(
  parameter int          DEPTH    = 16,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  output logic                       o_mem_req,
  output logic [15:0]                o_mem_addr,
  input  logic                       i_mem_ack,
  input  logic [7:0]                 i_mem_rdata,
  input  logic                       i_flush,
  input  logic [15:0]                i_flush_pc,
  input  logic [1:0]                 i_pop_len,
  output logic [7:0]                 o_q_byte0,
  output logic [7:0]                 o_q_byte1,
  output logic [7:0]                 o_q_byte2,
  output logic [$clog2(DEPTH):0]     o_q_count,
  output logic [15:0]                o_q_pc,
  output logic                       o_pop_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] PTR_TWO = PW'(2);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_ptr_s;
  logic [PW-1:0] r_ptr_e;
  logic [PW:0]   r_count;
  logic [15:0]   r_fetch_pc;
  logic [15:0]   r_q_pc;
  logic          r_mem_req;
  logic [15:0]   r_mem_addr;
  logic          r_pop_err;

  logic          w_wr;
  logic          w_pop_ok;
  logic          w_pop_bad;
  logic [PW:0]   w_pop_ext;
  logic [PW:0]   w_pop_amt;
  logic [PW:0]   w_wr_amt;
  logic [PW-1:0] w_ptr_s_nxt;
  logic [PW-1:0] w_ptr_e_nxt;
  logic [PW:0]   w_count_nxt;
  logic [15:0]   w_fetch_pc_nxt;
  logic [15:0]   w_q_pc_nxt;
  logic          w_mem_req_nxt;

  // Next-state computation: flush overrides both write and pop.
  always_comb begin
    w_pop_ext      = {{(PW-1){1'b0}}, i_pop_len};
    // Legality uses the count before this cycle's write.
    w_pop_bad      = (w_pop_ext > r_count);
    w_wr           = r_mem_req & i_mem_ack & ~i_flush;
    w_pop_ok       = ~i_flush & (i_pop_len != 2'd0) & ~w_pop_bad;
    w_pop_amt      = w_pop_ok ? w_pop_ext : {(PW+1){1'b0}};
    w_wr_amt       = {{PW{1'b0}}, w_wr};
    w_ptr_s_nxt    = r_ptr_s;
    w_ptr_e_nxt    = r_ptr_e;
    w_count_nxt    = r_count;
    w_fetch_pc_nxt = r_fetch_pc;
    w_q_pc_nxt     = r_q_pc;
    if (i_flush) begin
      w_ptr_s_nxt    = r_ptr_e;
      w_count_nxt    = {(PW+1){1'b0}};
      w_fetch_pc_nxt = i_flush_pc;
      w_q_pc_nxt     = i_flush_pc;
    end else begin
      if (w_wr) begin
        w_ptr_e_nxt    = r_ptr_e + PTR_ONE;
        w_fetch_pc_nxt = r_fetch_pc + 16'd1;
      end else begin
        w_ptr_e_nxt    = r_ptr_e;
        w_fetch_pc_nxt = r_fetch_pc;
      end
      if (w_pop_ok) begin
        w_ptr_s_nxt = r_ptr_s + w_pop_amt[PW-1:0];
        w_q_pc_nxt  = r_q_pc + {14'd0, i_pop_len};
      end else begin
        w_ptr_s_nxt = r_ptr_s;
        w_q_pc_nxt  = r_q_pc;
      end
      w_count_nxt = r_count + w_wr_amt - w_pop_amt;
    end
    // A raised request only needs a free slot; pops can only add slots, so
    // the request stays stable until ack or flush.
    w_mem_req_nxt = ~i_flush & (w_count_nxt < DEPTH_C);
  end

  // Control and pointer state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr_s    <= {PW{1'b0}};
      r_ptr_e    <= {PW{1'b0}};
      r_count    <= {(PW+1){1'b0}};
      r_fetch_pc <= RESET_PC;
      r_q_pc     <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_pop_err  <= 1'b0;
    end else begin
      r_ptr_s    <= w_ptr_s_nxt;
      r_ptr_e    <= w_ptr_e_nxt;
      r_count    <= w_count_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_q_pc     <= w_q_pc_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_fetch_pc_nxt;
      r_pop_err  <= w_pop_bad;
    end
  end

  // Byte storage; contents outside the valid window are don't-care.
  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_ptr_e] <= i_mem_rdata;
    end
  end

  assign o_mem_req  = r_mem_req;
  assign o_mem_addr = r_mem_addr;
  assign o_q_byte0  = r_mem[r_ptr_s];
  assign o_q_byte1  = r_mem[r_ptr_s + PTR_ONE];
  assign o_q_byte2  = r_mem[r_ptr_s + PTR_TWO];
  assign o_q_count  = r_count;
  assign o_q_pc     = r_q_pc;
  assign o_pop_err  = r_pop_err;

endmodule

// File: tb/tb_inst_prefetch.sv
// ---------------------------------------------------------------------------
// tb_inst_prefetch
//   Directed self-checking bench for inst_prefetch. Inputs change 1ns after
//   each rising edge; outputs are checked at the same point, so each check
//   sees the state produced by the preceding edge.
// ---------------------------------------------------------------------------
module tb_inst_prefetch;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        flush;
  logic [15:0] flush_pc;
  logic [1:0]  pop_len;
  logic [7:0]  q_byte0;
  logic [7:0]  q_byte1;
  logic [7:0]  q_byte2;
  logic [4:0]  q_count;
  logic [15:0] q_pc;
  logic        pop_err;

  int tests_run;
  int tests_failed;

  inst_prefetch #(.DEPTH(16), .RESET_PC(16'h0000)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .o_mem_req   (mem_req),
    .o_mem_addr  (mem_addr),
    .i_mem_ack   (mem_ack),
    .i_mem_rdata (mem_rdata),
    .i_flush     (flush),
    .i_flush_pc  (flush_pc),
    .i_pop_len   (pop_len),
    .o_q_byte0   (q_byte0),
    .o_q_byte1   (q_byte1),
    .o_q_byte2   (q_byte2),
    .o_q_count   (q_count),
    .o_q_pc      (q_pc),
    .o_pop_err   (pop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_pc;
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    flush     = 1'b0;
    flush_pc  = 16'h0000;
    pop_len   = 2'd0;
    step();
    step();

    // Reset state
    chk("rst_count",   {11'd0, q_count}, 16'd0);
    chk("rst_qpc",     q_pc,             16'h0000);
    chk("rst_req",     {15'd0, mem_req}, 16'd0);
    chk("rst_addr",    mem_addr,         16'h0000);
    chk("rst_pop_err", {15'd0, pop_err}, 16'd0);

    rst = 1'b0;
    step();
    chk("first_req",  {15'd0, mem_req}, 16'd1);
    chk("first_addr", mem_addr,         16'h0000);

    // Fill: constant ack, rdata = low byte of address
    mem_ack = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("fill_addr", mem_addr, 16'(i));
      chk("fill_req",  {15'd0, mem_req}, 16'd1);
      mem_rdata = mem_addr[7:0];
      step();
      chk("fill_count", {11'd0, q_count}, 16'(i + 1));
    end
    chk("full_req", {15'd0, mem_req}, 16'd0);
    chk("full_b0",  {8'd0, q_byte0}, 16'h0000);
    chk("full_b1",  {8'd0, q_byte1}, 16'h0001);
    chk("full_b2",  {8'd0, q_byte2}, 16'h0002);
    chk("full_qpc", q_pc, 16'h0000);
    step();
    chk("full_hold_count", {11'd0, q_count}, 16'd16);
    chk("full_hold_req",   {15'd0, mem_req}, 16'd0);

    // Pop 3 from full queue
    pop_len = 2'd3;
    step();
    mem_ack = 1'b0;
    pop_len = 2'd0;
    chk("pop3_qpc",   q_pc,             16'h0003);
    chk("pop3_b0",    {8'd0, q_byte0},  16'h0003);
    chk("pop3_count", {11'd0, q_count}, 16'd13);
    chk("pop3_req",   {15'd0, mem_req}, 16'd1);
    chk("pop3_addr",  mem_addr,         16'h0010);

    // Drain to count 5 (bytes 0B..0F), request pending at 0010
    pop_len = 2'd3;
    step();
    step();
    pop_len = 2'd2;
    step();
    chk("c5_count", {11'd0, q_count}, 16'd5);
    chk("c5_qpc",   q_pc,             16'h000B);

    // Pop 2 concurrent with an ack of byte 10
    mem_ack   = 1'b1;
    mem_rdata = 8'h10;
    pop_len   = 2'd2;
    step();
    mem_ack = 1'b0;
    pop_len = 2'd0;
    chk("popwr_count", {11'd0, q_count}, 16'd4);
    chk("popwr_qpc",   q_pc,             16'h000D);
    chk("popwr_b0",    {8'd0, q_byte0},  16'h000D);
    chk("popwr_b2",    {8'd0, q_byte2},  16'h000F);
    chk("popwr_addr",  mem_addr,         16'h0011);
    pop_len = 2'd3;
    step();
    pop_len = 2'd0;
    chk("tail_count", {11'd0, q_count}, 16'd1);
    chk("tail_b0",    {8'd0, q_byte0},  16'h0010);

    // Illegal pop: count 1, pop 2
    pop_len = 2'd2;
    step();
    pop_len = 2'd0;
    chk("perr_pulse", {15'd0, pop_err}, 16'd1);
    chk("perr_count", {11'd0, q_count}, 16'd1);
    chk("perr_qpc",   q_pc,             16'h0010);
    chk("perr_b0",    {8'd0, q_byte0},  16'h0010);
    step();
    chk("perr_clear", {15'd0, pop_err}, 16'd0);
    chk("perr_count2", {11'd0, q_count}, 16'd1);

    // Flush with a same-cycle ack that must be discarded
    chk("pend_req",  {15'd0, mem_req}, 16'd1);
    chk("pend_addr", mem_addr,         16'h0011);
    flush     = 1'b1;
    flush_pc  = 16'hC000;
    mem_ack   = 1'b1;
    mem_rdata = 8'hAA;
    step();
    flush   = 1'b0;
    mem_ack = 1'b0;
    chk("fl_count", {11'd0, q_count}, 16'd0);
    chk("fl_qpc",   q_pc,             16'hC000);
    chk("fl_req_lo", {15'd0, mem_req}, 16'd0);
    step();
    chk("fl_req_hi", {15'd0, mem_req}, 16'd1);
    chk("fl_addr",   mem_addr,         16'hC000);
    chk("fl_count2", {11'd0, q_count}, 16'd0);

    // Flush to FFFE, streaming with ack and pop of 1
    flush    = 1'b1;
    flush_pc = 16'hFFFE;
    step();
    flush = 1'b0;
    step();
    chk("wrap_req",  {15'd0, mem_req}, 16'd1);
    chk("wrap_addr", mem_addr,         16'hFFFE);
    mem_ack   = 1'b1;
    mem_rdata = mem_addr[7:0];
    step();
    chk("wrap_first_count", {11'd0, q_count}, 16'd1);
    chk("wrap_first_b0",    {8'd0, q_byte0},  16'h00FE);
    chk("wrap_first_addr",  mem_addr,         16'hFFFF);
    exp_pc = 16'hFFFE;
    for (int k = 0; k < 40; k++) begin
      pop_len   = 2'd1;
      mem_rdata = mem_addr[7:0];
      step();
      exp_pc = exp_pc + 16'd1;
      chk("stream_qpc",   q_pc,             exp_pc);
      chk("stream_b0",    {8'd0, q_byte0},  {8'd0, exp_pc[7:0]});
      chk("stream_count", {11'd0, q_count}, 16'd1);
      chk("stream_addr",  mem_addr,         exp_pc + 16'd1);
    end
    pop_len = 2'd0;
    for (int k = 0; k < 3; k++) begin
      mem_rdata = mem_addr[7:0];
      step();
    end
    mem_ack = 1'b0;
    chk("grow_count", {11'd0, q_count}, 16'd4);
    chk("grow_qpc",   q_pc,             exp_pc);
    chk("grow_b0",    {8'd0, q_byte0},  {8'd0, exp_pc[7:0]});
    chk("grow_b1",    {8'd0, q_byte1},  {8'd0, exp_pc[7:0] + 8'd1});
    chk("grow_b2",    {8'd0, q_byte2},  {8'd0, exp_pc[7:0] + 8'd2});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
